w5300_tx_arbiter: RTL and testbench

Parametrised N-channel transmit scheduler sitting between per-channel TX buffer RAMs and the single W5300 entry engine.
- Generalises the single fixed-destination TX path (one RAM, constant IP/port/size) to CHANNELS independent requesters, each with its own destination, size and buffer.
- Latches requests, arbitrates round-robin, drives the entry handshake, muxes buffer data and reports per-channel completion/error.

---
 rtl/w5300_tx_arbiter.sv | 258 +++++++++++++++++++++++++
 tb/tb_w5300_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/w5300_tx_arbiter.sv
// w5300_tx_arbiter: round-robin transmit scheduler between CHANNELS TX
// buffers and the single W5300 entry engine.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   ch_req            per-channel request pulse
//   ch_dest_ip/port   per-channel destination (ch0 in LSBs)
//   ch_size           per-channel transfer size in bytes
//   ch_buf_data       read data from every channel buffer
//   ch_buf_addr       shared buffer read address (= tx_buffer_addr)
//   ch_ack, ch_err    one-cycle completion / error pulse per channel
//   tx_req            request to entry engine
//   dest_ip/dest_port/tx_data_size  latched fields of granted channel
//   tx_data           buffer data of granted channel (combinational)
//   tx_buffer_addr    buffer address from entry engine
//   busy_n, err_code  entry engine status
//   active_ch         granted channel index
//   idle              idle with no pending request
//   stat_done, stat_overrun  per-channel 16-bit saturating counters,
//                     present only when W5300_TX_STATS_EN is defined
//
// Optional feature macro: W5300_TX_STATS_EN
module w5300_tx_arbiter #(
    parameter int unsigned CHANNELS       = 4,
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned SIZE_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CHANNELS-1:0]              ch_req,
    input  logic [CHANNELS*32-1:0]           ch_dest_ip,
    input  logic [CHANNELS*16-1:0]           ch_dest_port,
    input  logic [CHANNELS*SIZE_WIDTH-1:0]   ch_size,
    input  logic [CHANNELS*DATA_WIDTH-1:0]   ch_buf_data,
    output logic [ADDR_WIDTH-1:0]            ch_buf_addr,
    output logic [CHANNELS-1:0]              ch_ack,
    output logic [CHANNELS-1:0]              ch_err,
    output logic                             tx_req,
    output logic [31:0]                      dest_ip,
    output logic [15:0]                      dest_port,
    output logic [SIZE_WIDTH-1:0]            tx_data_size,
    output logic [DATA_WIDTH-1:0]            tx_data,
    input  logic [ADDR_WIDTH-1:0]            tx_buffer_addr,
    input  logic                             busy_n,
    input  logic [2:0]                       err_code,
    output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] active_ch,
`ifdef W5300_TX_STATS_EN
    output logic [CHANNELS*16-1:0]           stat_done,
    output logic [CHANNELS*16-1:0]           stat_overrun,
`endif
    output logic                             idle
);

    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_REQ,
        S_WAIT_DONE,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CHANNELS-1:0]     r_pending;
    logic [CHANNELS-1:0]     w_pending_nxt;
    logic [CH_W-1:0]         r_ptr;
    logic [CH_W-1:0]         r_sel;
    logic [CH_W-1:0]         w_pick;
    logic                    w_pick_vld;
    logic [31:0]             w_idx;
    logic [31:0]             w_sel_i;
    logic [31:0]             w_act_i;
    logic [CHANNELS-1:0]     w_sel_oh;
    logic                    w_enter_done;
    logic                    w_done_err;
    logic [TO_W-1:0]         r_tmo_cnt;
    logic                    w_tmo_hit;

    logic [CHANNELS-1:0]     r_ch_ack;
    logic [CHANNELS-1:0]     r_ch_err;
    logic                    r_tx_req;
    logic [31:0]             r_dest_ip;
    logic [15:0]             r_dest_port;
    logic [SIZE_WIDTH-1:0]   r_tx_data_size;
    logic [CH_W-1:0]         r_active_ch;
    logic                    r_idle;

    assign w_sel_i      = 32'(r_sel);
    assign w_act_i      = 32'(r_active_ch);
    assign w_sel_oh     = CHANNELS'(1) << r_sel;
    assign w_tmo_hit    = (r_tmo_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_enter_done = (w_state_nxt == S_DONE) && (r_state != S_DONE);

    // Pass-through buffer address and data mux of the granted channel
    assign ch_buf_addr  = tx_buffer_addr;
    assign tx_data      = ch_buf_data[w_act_i*DATA_WIDTH +: DATA_WIDTH];

    assign ch_ack       = r_ch_ack;
    assign ch_err       = r_ch_err;
    assign tx_req       = r_tx_req;
    assign dest_ip      = r_dest_ip;
    assign dest_port    = r_dest_port;
    assign tx_data_size = r_tx_data_size;
    assign active_ch    = r_active_ch;
    assign idle         = r_idle;

    // Round-robin pick: first pending index at or after the pointer
    always_comb begin
        w_pick_vld = 1'b0;
        w_pick     = '0;
        w_idx      = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            w_idx = 32'(r_ptr) + k;
            if (w_idx >= CHANNELS) begin
                w_idx = w_idx - CHANNELS;
            end
            if (!w_pick_vld && r_pending[CH_W'(w_idx)]) begin
                w_pick_vld = 1'b1;
                w_pick     = CH_W'(w_idx);
            end
        end
    end

    // Pending set on request unless already pending; cleared as the ack is issued
    assign w_pending_nxt = (r_pending & ~(w_enter_done ? w_sel_oh : '0))
                         | (ch_req & ~r_pending);

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_done_err  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (ch_size[w_sel_i*SIZE_WIDTH +: SIZE_WIDTH] == '0) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (!busy_n) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_done_err  = 1'b1;
                end
            end
            S_WAIT_DONE: begin
                if (busy_n) begin
                    w_state_nxt = S_DONE;
                    w_done_err  = (err_code != 3'd0);
                end else if (w_tmo_hit) begin
                    w_state_nxt = S_DONE;
                    w_done_err  = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, latched fields and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_pending      <= '0;
            r_ptr          <= '0;
            r_sel          <= '0;
            r_tmo_cnt      <= '0;
            r_ch_ack       <= '0;
            r_ch_err       <= '0;
            r_tx_req       <= 1'b0;
            r_dest_ip      <= '0;
            r_dest_port    <= '0;
            r_tx_data_size <= '0;
            r_active_ch    <= '0;
            r_idle         <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_tx_req  <= (w_state_nxt == S_REQ);
            r_ch_ack  <= w_enter_done ? w_sel_oh : '0;
            r_ch_err  <= (w_enter_done && w_done_err) ? w_sel_oh : '0;
            r_idle    <= (w_state_nxt == S_IDLE) && (w_pending_nxt == '0);

            // Phase timer restarts on every state change
            if ((w_state_nxt != r_state) ||
                ((r_state != S_REQ) && (r_state != S_WAIT_DONE))) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            if ((r_state == S_IDLE) && w_pick_vld) begin
                r_sel <= w_pick;
            end

            if (r_state == S_GRANT) begin
                r_active_ch    <= r_sel;
                r_dest_ip      <= ch_dest_ip[w_sel_i*32 +: 32];
                r_dest_port    <= ch_dest_port[w_sel_i*16 +: 16];
                r_tx_data_size <= ch_size[w_sel_i*SIZE_WIDTH +: SIZE_WIDTH];
            end

            if (r_state == S_DONE) begin
                if (r_active_ch == CH_W'(CHANNELS - 1)) begin
                    r_ptr <= '0;
                end else begin
                    r_ptr <= r_active_ch + 1'b1;
                end
            end
        end
    end

`ifdef W5300_TX_STATS_EN
    logic [15:0] r_stat_done    [CHANNELS];
    logic [15:0] r_stat_overrun [CHANNELS];

    // Saturating per-channel counters: clean completions and dropped requests
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_stat_done[i]    <= '0;
                r_stat_overrun[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (r_ch_ack[i] && !r_ch_err[i] && (r_stat_done[i] != 16'hFFFF)) begin
                    r_stat_done[i] <= r_stat_done[i] + 16'd1;
                end
                if (ch_req[i] && r_pending[i] && (r_stat_overrun[i] != 16'hFFFF)) begin
                    r_stat_overrun[i] <= r_stat_overrun[i] + 16'd1;
                end
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_stat
        assign stat_done[g*16 +: 16]    = r_stat_done[g];
        assign stat_overrun[g*16 +: 16] = r_stat_overrun[g];
    end
`endif

endmodule

// File: tb/tb_w5300_tx_arbiter.sv
// Directed bench for w5300_tx_arbiter: u_dut_a (long timeout) is served by
// an entry-engine model; u_dut_b (TIMEOUT_CYCLES=16) sees busy_n stuck high.
module tb_w5300_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   ch_req;
    logic [127:0] ch_dest_ip;
    logic [63:0]  ch_dest_port;
    logic [127:0] ch_size;
    logic [63:0]  ch_buf_data;
    logic [7:0]   tx_buffer_addr;
    logic         busy_n;
    logic [2:0]   err_code;

    logic [7:0]   a_ch_buf_addr, b_ch_buf_addr;
    logic [3:0]   a_ch_ack, a_ch_err, b_ch_ack, b_ch_err;
    logic         a_tx_req, b_tx_req, a_idle, b_idle;
    logic [31:0]  a_dest_ip, b_dest_ip;
    logic [15:0]  a_dest_port, b_dest_port;
    logic [31:0]  a_tx_data_size, b_tx_data_size;
    logic [15:0]  a_tx_data, b_tx_data;
    logic [1:0]   a_active_ch, b_active_ch;
`ifdef W5300_TX_STATS_EN
    logic [63:0]  a_stat_done, a_stat_overrun, b_stat_done, b_stat_overrun;
`endif

    int n_vec = 0;
    int n_err = 0;
    int eng_hold = 50;
    logic [2:0] eng_err = 3'd0;

    always #5 clk = ~clk;

    w5300_tx_arbiter #(.CHANNELS(4), .TIMEOUT_CYCLES(1000)) u_dut_a (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_dest_ip(ch_dest_ip),
        .ch_dest_port(ch_dest_port), .ch_size(ch_size), .ch_buf_data(ch_buf_data),
        .ch_buf_addr(a_ch_buf_addr), .ch_ack(a_ch_ack), .ch_err(a_ch_err),
        .tx_req(a_tx_req), .dest_ip(a_dest_ip), .dest_port(a_dest_port),
        .tx_data_size(a_tx_data_size), .tx_data(a_tx_data),
        .tx_buffer_addr(tx_buffer_addr), .busy_n(busy_n), .err_code(err_code),
        .active_ch(a_active_ch),
`ifdef W5300_TX_STATS_EN
        .stat_done(a_stat_done), .stat_overrun(a_stat_overrun),
`endif
        .idle(a_idle)
    );

    w5300_tx_arbiter #(.CHANNELS(4), .TIMEOUT_CYCLES(16)) u_dut_b (
        .clk(clk), .rst(rst), .ch_req(ch_req), .ch_dest_ip(ch_dest_ip),
        .ch_dest_port(ch_dest_port), .ch_size(ch_size), .ch_buf_data(ch_buf_data),
        .ch_buf_addr(b_ch_buf_addr), .ch_ack(b_ch_ack), .ch_err(b_ch_err),
        .tx_req(b_tx_req), .dest_ip(b_dest_ip), .dest_port(b_dest_port),
        .tx_data_size(b_tx_data_size), .tx_data(b_tx_data),
        .tx_buffer_addr(tx_buffer_addr), .busy_n(1'b1), .err_code(3'd0),
        .active_ch(b_active_ch),
`ifdef W5300_TX_STATS_EN
        .stat_done(b_stat_done), .stat_overrun(b_stat_overrun),
`endif
        .idle(b_idle)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_req(input logic [3:0] mask);
        ch_req = mask;
        tick();
        ch_req = 4'd0;
    endtask

    // Bounded wait for the next ack on u_dut_a; returns zeros on expiry
    task automatic wait_ack_a(output logic [3:0] ack, output logic [3:0] err,
                              output logic [1:0] ch);
        ack = 4'd0;
        err = 4'd0;
        ch  = 2'd0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (a_ch_ack != 4'd0) begin
                ack = a_ch_ack;
                err = a_ch_err;
                ch  = a_active_ch;
                return;
            end
        end
    endtask

    // Entry engine model: busy 2 cycles after tx_req, busy for eng_hold cycles
    initial begin
        busy_n   = 1'b1;
        err_code = 3'd0;
        forever begin
            @(posedge a_tx_req);
            repeat (2) @(posedge clk);
            #1 busy_n = 1'b0;
            repeat (eng_hold) @(posedge clk);
            #1;
            err_code = eng_err;
            busy_n   = 1'b1;
            @(posedge clk);
            #1 err_code = 3'd0;
        end
    end

    initial begin
        logic [3:0] ack, err;
        logic [1:0] ch;
        int cnt;

        rst            = 1'b1;
        ch_req         = 4'd0;
        ch_dest_ip     = {32'hC0A8_0004, 32'hC0A8_0003, 32'hC0A8_0002, 32'hC0A8_0001};
        ch_dest_port   = {16'h4444, 16'h3333, 16'h2222, 16'h1234};
        ch_size        = {32'd300, 32'd200, 32'd100, 32'd400};
        ch_buf_data    = {16'h3333, 16'h2222, 16'h1111, 16'h0000};
        tx_buffer_addr = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check_eq("rst_tx_req", 64'(a_tx_req), 64'd0);
        check_eq("rst_ack", 64'(a_ch_ack), 64'd0);
        check_eq("rst_err", 64'(a_ch_err), 64'd0);
        check_eq("rst_idle", 64'(a_idle), 64'd1);
        check_eq("rst_fields", {a_dest_ip, a_dest_port, 14'd0, a_active_ch}, 64'd0);
        check_eq("rst_size", 64'(a_tx_data_size), 64'd0);

        // Round-robin from pointer 0: four simultaneous requests
        pulse_req(4'b1111);
        for (int i = 0; i < 4; i++) begin
            wait_ack_a(ack, err, ch);
            check_eq($sformatf("rr_ack%0d", i), 64'(ack), 64'(4'd1 << i));
            check_eq($sformatf("rr_err%0d", i), 64'(err), 64'd0);
            check_eq($sformatf("rr_ch%0d", i), 64'(ch), 64'(i));
        end

        // Single request on ch0: latency and latched fields
        repeat (3) tick();
        pulse_req(4'b0001);
        check_eq("single_pending_idle", 64'(a_idle), 64'd0);
        tick();
        check_eq("single_grant_txreq", 64'(a_tx_req), 64'd0);
        tick();
        check_eq("single_txreq_n3", 64'(a_tx_req), 64'd1);
        check_eq("single_ip", 64'(a_dest_ip), 64'hC0A8_0001);
        check_eq("single_port", 64'(a_dest_port), 64'h1234);
        check_eq("single_size", 64'(a_tx_data_size), 64'd400);
        ch_dest_ip[31:0] = 32'hDEAD_BEEF;
        tick();
        check_eq("single_ip_stable", 64'(a_dest_ip), 64'hC0A8_0001);
        ch_dest_ip[31:0] = 32'hC0A8_0001;
        wait_ack_a(ack, err, ch);
        check_eq("single_ack", 64'(ack), 64'h1);
        check_eq("single_err", 64'(err), 64'd0);
        tick();
        check_eq("single_ack_oneshot", 64'(a_ch_ack), 64'd0);
        check_eq("single_idle_after", 64'(a_idle), 64'd1);

        // Pointer now 1: 0011 grants ch1 then ch0
        pulse_req(4'b0011);
        wait_ack_a(ack, err, ch);
        check_eq("rr2_first", 64'(ack), 64'h2);
        wait_ack_a(ack, err, ch);
        check_eq("rr2_second", 64'(ack), 64'h1);

        // Data mux on ch2
        tick();
        pulse_req(4'b0100);
        tick();
        tick();
        check_eq("mux_active", 64'(a_active_ch), 64'd2);
        tx_buffer_addr    = 8'h10;
        ch_buf_data[47:32] = 16'hA5A5;
        #1;
        check_eq("mux_addr", 64'(a_ch_buf_addr), 64'h10);
        check_eq("mux_data", 64'(a_tx_data), 64'hA5A5);
        ch_buf_data[47:32] = 16'h5A5A;
        #1;
        check_eq("mux_data2", 64'(a_tx_data), 64'h5A5A);
        wait_ack_a(ack, err, ch);
        check_eq("mux_ack", 64'(ack), 64'h4);

        // Zero-size transfer on ch1
        tick();
        ch_size[63:32] = 32'd0;
        pulse_req(4'b0010);
        tick();
        check_eq("zero_n2_ack", 64'(a_ch_ack), 64'd0);
        tick();
        check_eq("zero_n3_ack", 64'(a_ch_ack), 64'h2);
        check_eq("zero_n3_err", 64'(a_ch_err), 64'd0);
        check_eq("zero_no_txreq", 64'(a_tx_req), 64'd0);
        ch_size[63:32] = 32'd100;

        // Engine error code on ch3
        tick();
        eng_err = 3'd2;
        pulse_req(4'b1000);
        wait_ack_a(ack, err, ch);
        check_eq("errc_ack", 64'(ack), 64'h8);
        check_eq("errc_err", 64'(err), 64'h8);
        eng_err = 3'd0;

        // REQ timeout on u_dut_b (busy_n never drops)
        for (int i = 0; i < 600 && !b_idle; i++) tick();
        pulse_req(4'b0001);
        tick();
        tick();
        cnt = 0;
        for (int i = 0; i < 40 && b_tx_req; i++) begin
            cnt++;
            tick();
        end
        check_eq("tmo_req_cycles", 64'(cnt), 64'd16);
        check_eq("tmo_ack", 64'(b_ch_ack), 64'h1);
        check_eq("tmo_err", 64'(b_ch_err), 64'h1);
        wait_ack_a(ack, err, ch);
        check_eq("tmo_a_ack", 64'(ack), 64'h1);
        repeat (3) tick();

        // Overrun then reset in WAIT_DONE
        pulse_req(4'b0001);
        pulse_req(4'b0001);
        for (int i = 0; i < 20 && !a_tx_req; i++) tick();
        repeat (5) tick();
        check_eq("wait_busy_n", 64'(busy_n), 64'd0);
`ifdef W5300_TX_STATS_EN
        check_eq("stat_overrun0", 64'(a_stat_overrun[15:0]), 64'd1);
        check_eq("stat_done0", 64'(a_stat_done[15:0]), 64'd4);
`endif
        rst = 1'b1;
        tick();
        check_eq("rst_mid_txreq", 64'(a_tx_req), 64'd0);
        check_eq("rst_mid_idle", 64'(a_idle), 64'd1);
        check_eq("rst_mid_ip", 64'(a_dest_ip), 64'd0);
`ifdef W5300_TX_STATS_EN
        check_eq("rst_mid_stat", 64'(a_stat_overrun[15:0]), 64'd0);
`endif
        rst = 1'b0;
        repeat (4) tick();
        check_eq("rst_lost_idle", 64'(a_idle), 64'd1);
        check_eq("rst_lost_txreq", 64'(a_tx_req), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
